// File: rtl/ts_queue.sv
// ts_queue: first-word-fall-through queue of 56-bit timestamp records
// between capture logic and the register block read port.
module ts_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        q_rst,
    input  logic        ts_wr_en,
    input  logic [55:0] ts_wr_data,
    input  logic        q_rd_en,
    output logic [7:0]  q_rd_stat,
    output logic [55:0] q_rd_data,
    output logic        q_full,
    output logic        q_ovf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    logic [55:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  flush;

    assign flush = rst | q_rst;

    // A pop frees a slot in the same cycle, so a push at full still fits
    // when it is paired with an accepted pop.
    always_comb begin
        pop_ok  = q_rd_en && (count != '0);
        push_ok = ts_wr_en && ((count != CNT_MAX) || pop_ok);
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // Pointer, occupancy and flag state; a flush discards same-cycle traffic.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q_full <= 1'b0;
            q_ovf  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count  <= count_nxt;
            q_full <= (count_nxt == CNT_MAX);
            if (ts_wr_en && !push_ok) begin
                q_ovf <= 1'b1;
            end
        end
    end

    // Record storage; contents are left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (!flush && push_ok) begin
            mem[wr_ptr] <= ts_wr_data;
        end
    end

    assign q_rd_data = (count != '0) ? mem[rd_ptr] : 56'h0;
    assign q_rd_stat = 8'(count);

endmodule

// File: tb/tb_ts_queue.sv
// tb_ts_queue: directed self-checking bench for ts_queue
// (16-entry default configuration).
module tb_ts_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        q_rst;
    logic        ts_wr_en;
    logic [55:0] ts_wr_data;
    logic        q_rd_en;
    logic [7:0]  q_rd_stat;
    logic [55:0] q_rd_data;
    logic        q_full;
    logic        q_ovf;

    int checks = 0;
    int errors = 0;

    ts_queue #(.DEPTH_LOG2(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .q_rst      (q_rst),
        .ts_wr_en   (ts_wr_en),
        .ts_wr_data (ts_wr_data),
        .q_rd_en    (q_rd_en),
        .q_rd_stat  (q_rd_stat),
        .q_rd_data  (q_rd_data),
        .q_full     (q_full),
        .q_ovf      (q_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [55:0] d);
        ts_wr_en   = 1'b1;
        ts_wr_data = d;
        step();
        ts_wr_en   = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [55:0] d);
        q_rd_en = 1'b1;
        check(tag, 64'(q_rd_data), 64'(d));
        step();
        q_rd_en = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        q_rst      = 1'b0;
        ts_wr_en   = 1'b1;
        ts_wr_data = 56'hDEAD;
        q_rd_en    = 1'b1;
        step();
        step();
        rst      = 1'b0;
        ts_wr_en = 1'b0;
        q_rd_en  = 1'b0;
        check("rst_stat", 64'(q_rd_stat), 64'd0);
        check("rst_data", 64'(q_rd_data), 64'd0);
        check("rst_full", 64'(q_full), 64'd0);
        check("rst_ovf", 64'(q_ovf), 64'd0);

        // single record
        push(56'h00_1234_5678_9ABC);
        check("one_stat", 64'(q_rd_stat), 64'd1);
        pop_expect("one_data", 56'h00_1234_5678_9ABC);
        check("one_stat_after", 64'(q_rd_stat), 64'd0);
        check("one_data_after", 64'(q_rd_data), 64'd0);

        // fill and overflow
        for (int i = 1; i <= 17; i++) begin
            push(56'(i));
            if (i == 15) check("fill15_full", 64'(q_full), 64'd0);
            if (i == 16) begin
                check("fill16_full", 64'(q_full), 64'd1);
                check("fill16_stat", 64'(q_rd_stat), 64'd16);
                check("fill16_ovf", 64'(q_ovf), 64'd0);
            end
        end
        check("ovf_set", 64'(q_ovf), 64'd1);
        check("ovf_stat", 64'(q_rd_stat), 64'd16);
        for (int i = 1; i <= 16; i++) begin
            pop_expect($sformatf("fill_pop%0d", i), 56'(i));
        end
        check("drain_stat", 64'(q_rd_stat), 64'd0);
        check("drain_data", 64'(q_rd_data), 64'd0);
        check("drain_full", 64'(q_full), 64'd0);
        check("ovf_sticky", 64'(q_ovf), 64'd1);

        // simultaneous push+pop at full
        q_rst = 1'b1;
        step();
        q_rst = 1'b0;
        check("qrst_ovf", 64'(q_ovf), 64'd0);
        for (int i = 0; i < 16; i++) push(56'h100 + 56'(i));
        ts_wr_en   = 1'b1;
        ts_wr_data = 56'hAA;
        pop_expect("pp_full_head", 56'h100);
        ts_wr_en   = 1'b0;
        check("pp_full_stat", 64'(q_rd_stat), 64'd16);
        check("pp_full_ovf", 64'(q_ovf), 64'd0);
        check("pp_full_full", 64'(q_full), 64'd1);
        for (int i = 1; i < 16; i++) begin
            pop_expect($sformatf("pp_pop%0d", i), 56'h100 + 56'(i));
        end
        pop_expect("pp_last_aa", 56'hAA);
        check("pp_empty", 64'(q_rd_stat), 64'd0);

        // empty-side corners
        q_rd_en = 1'b1;
        step();
        q_rd_en = 1'b0;
        check("pop_empty_stat", 64'(q_rd_stat), 64'd0);
        ts_wr_en   = 1'b1;
        ts_wr_data = 56'h55;
        q_rd_en    = 1'b1;
        step();
        ts_wr_en = 1'b0;
        q_rd_en  = 1'b0;
        check("pp_empty_stat", 64'(q_rd_stat), 64'd1);
        pop_expect("pp_empty_data", 56'h55);
        check("pp_empty_after", 64'(q_rd_stat), 64'd0);

        // flush with 5 entries and overflow pending
        for (int i = 0; i < 17; i++) push(56'h200 + 56'(i));
        for (int i = 0; i < 11; i++) begin
            pop_expect($sformatf("fl_pop%0d", i), 56'h200 + 56'(i));
        end
        check("fl_pre_stat", 64'(q_rd_stat), 64'd5);
        check("fl_pre_ovf", 64'(q_ovf), 64'd1);
        q_rst      = 1'b1;
        ts_wr_en   = 1'b1;
        ts_wr_data = 56'h99;
        step();
        q_rst    = 1'b0;
        ts_wr_en = 1'b0;
        check("fl_stat", 64'(q_rd_stat), 64'd0);
        check("fl_ovf", 64'(q_ovf), 64'd0);
        check("fl_data", 64'(q_rd_data), 64'd0);
        check("fl_full", 64'(q_full), 64'd0);
        push(56'h77);
        check("fl_push_stat", 64'(q_rd_stat), 64'd1);
        check("fl_push_data", 64'(q_rd_data), 64'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
